osd_char_ctrl: RTL and testbench

OSD_CHAR_CTRL -- requirements
Module: osd_char_ctrl

---
 rtl/osd_pkg.sv | 21 ++
 rtl/osd_char_ctrl_if.sv | 26 ++
 rtl/osd_video_delay.sv | 27 ++
 rtl/osd_char_ctrl.sv | 129 ++++++++++++
 tb/tb_osd_char_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/osd_pkg.sv
// Shared constants and the video bus record for the OSD character overlay.
package osd_pkg;

    localparam int unsigned BMP_W_DEF     = 256;
    localparam int unsigned BMP_H_DEF     = 64;
    localparam int unsigned BYTES_PER_ROW = BMP_W_DEF / 8;
    localparam int unsigned PIPE_LAT      = 3;
    localparam int unsigned ROM_AW        = 11;
    localparam int unsigned CNT_W         = 12;
    localparam int unsigned PIX_W         = 24;
    localparam int unsigned VID_W         = PIX_W + 3;

    // One video beat: timing flags plus RGB pixel, 27 bits in total.
    typedef struct packed {
        logic             hs;
        logic             vs;
        logic             de;
        logic [PIX_W-1:0] data;
    } vid_t;

endpackage

// File: rtl/osd_char_ctrl_if.sv
// Video in/out and OSD ROM port bundle.
interface osd_char_ctrl_if;
    import osd_pkg::*;

    logic              i_hs;
    logic              i_vs;
    logic              i_de;
    logic [PIX_W-1:0]  i_data;
    logic              o_hs;
    logic              o_vs;
    logic              o_de;
    logic [PIX_W-1:0]  o_data;
    logic [ROM_AW-1:0] rom_addr;
    logic [7:0]        rom_data;

    modport slave (
        input  i_hs, i_vs, i_de, i_data, rom_data,
        output o_hs, o_vs, o_de, o_data, rom_addr
    );

    modport master (
        output i_hs, i_vs, i_de, i_data, rom_data,
        input  o_hs, o_vs, o_de, o_data, rom_addr
    );

endinterface

// File: rtl/osd_video_delay.sv
// Fixed-depth shift register for the 27-bit timing/pixel bus.
module osd_video_delay
    import osd_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [VID_W-1:0] din,
    output logic [VID_W-1:0] dout
);

    logic [VID_W-1:0] pipe [DEPTH];

    // Shift the bus one stage per clock; reset flushes every stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/osd_char_ctrl.sv
// Overlays a 1-bpp ROM bitmap onto a video stream with a fixed 3-clock latency.
module osd_char_ctrl
    import osd_pkg::*;
#(
    parameter int unsigned BMP_W     = BMP_W_DEF,
    parameter int unsigned BMP_H     = BMP_H_DEF,
    parameter logic [23:0] OSD_COLOR = 24'hFF0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             osd_en,
    input  logic [CNT_W-1:0] pos_x,
    input  logic [CNT_W-1:0] pos_y,
    osd_char_ctrl_if.slave   bus
);

    localparam int unsigned BPR = BMP_W / 8;

    logic [CNT_W-1:0] x_cnt;
    logic [CNT_W-1:0] y_cnt;
    logic [CNT_W-1:0] pos_x_l;
    logic [CNT_W-1:0] pos_y_l;
    logic             en_l;
    logic             vs_q;
    logic             de_q;
    logic             hit1;
    logic             hit2;
    logic [2:0]       bit1;
    logic [2:0]       bit2;

    logic             vs_rise_c;
    logic             de_fall_c;
    logic             hit_c;
    logic [12:0]      x13_c;
    logic [12:0]      y13_c;
    logic [12:0]      px13_c;
    logic [12:0]      py13_c;
    logic [12:0]      dx_c;
    logic [12:0]      dy_c;
    vid_t             vid_in_c;
    vid_t             vid_d;

    // Edge detects and the 13-bit window test (13 bits so pos+size never wraps).
    always_comb begin
        vid_in_c  = '{hs: bus.i_hs, vs: bus.i_vs, de: bus.i_de, data: bus.i_data};
        vs_rise_c = bus.i_vs & ~vs_q;
        de_fall_c = de_q & ~bus.i_de;
        x13_c     = {1'b0, x_cnt};
        y13_c     = {1'b0, y_cnt};
        px13_c    = {1'b0, pos_x_l};
        py13_c    = {1'b0, pos_y_l};
        dx_c      = x13_c - px13_c;
        dy_c      = y13_c - py13_c;
        hit_c     = en_l && bus.i_de
                    && (x13_c >= px13_c) && (x13_c < px13_c + 13'(BMP_W))
                    && (y13_c >= py13_c) && (y13_c < py13_c + 13'(BMP_H));
    end

    // Pixel/line counters and frame-start latching of the overlay configuration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt   <= '0;
            y_cnt   <= '0;
            pos_x_l <= '0;
            pos_y_l <= '0;
            en_l    <= 1'b0;
            vs_q    <= 1'b0;
            de_q    <= 1'b0;
        end else begin
            vs_q <= bus.i_vs;
            de_q <= bus.i_de;
            if (!bus.i_de)                x_cnt <= '0;
            else if (x_cnt != '1)         x_cnt <= x_cnt + 12'd1;
            if (vs_rise_c) begin
                y_cnt   <= '0;
                en_l    <= osd_en;
                pos_x_l <= pos_x;
                pos_y_l <= pos_y;
            end else if (de_fall_c && (y_cnt != '1)) begin
                y_cnt   <= y_cnt + 12'd1;
            end
        end
    end

    // ROM address on hit (held otherwise) plus hit/bit-select pipeline matching ROM latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rom_addr <= '0;
            hit1         <= 1'b0;
            hit2         <= 1'b0;
            bit1         <= '0;
            bit2         <= '0;
        end else begin
            if (hit_c) begin
                bus.rom_addr <= ROM_AW'(32'(dy_c) * BPR + 32'(dx_c >> 3));
            end
            hit1 <= hit_c;
            bit1 <= 3'd7 - dx_c[2:0];
            hit2 <= hit1;
            bit2 <= bit1;
        end
    end

    // First PIPE_LAT-1 stages of the video delay; the final stage is the output register.
    osd_video_delay #(
        .DEPTH (PIPE_LAT - 1)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (vid_in_c),
        .dout  (vid_d)
    );

    // Output stage: substitute the OSD colour where the selected bitmap bit is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.o_hs   <= 1'b0;
            bus.o_vs   <= 1'b0;
            bus.o_de   <= 1'b0;
            bus.o_data <= '0;
        end else begin
            bus.o_hs   <= vid_d.hs;
            bus.o_vs   <= vid_d.vs;
            bus.o_de   <= vid_d.de;
            bus.o_data <= (hit2 && bus.rom_data[bit2]) ? OSD_COLOR : vid_d.data;
        end
    end

endmodule

// File: tb/tb_osd_char_ctrl.sv
// Randomized self-checking bench for osd_char_ctrl with a frame-level reference model.
module tb_osd_char_ctrl;
    import osd_pkg::*;

    localparam logic [23:0] COLOR = 24'hFF0000;
    localparam int BW  = 256;
    localparam int BH  = 64;
    localparam int BPR = BW / 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        osd_en = 1'b0;
    logic [11:0] pos_x = '0;
    logic [11:0] pos_y = '0;

    osd_char_ctrl_if bus();

    osd_char_ctrl #(
        .BMP_W     (BW),
        .BMP_H     (BH),
        .OSD_COLOR (COLOR)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .osd_en (osd_en),
        .pos_x  (pos_x),
        .pos_y  (pos_y),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // External synchronous OSD ROM: data one clock after the address is sampled.
    logic [7:0] rom [2048];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pixel position, latched frame config, and a 3-beat output history.
    int          mx, my, m_px, m_py;
    bit          m_en, m_pvs, m_pde;
    logic [26:0] mh [3];
    logic [10:0] m_addr;

    task automatic model_reset();
        mx = 0; my = 0; m_px = 0; m_py = 0;
        m_en = 0; m_pvs = 0; m_pde = 0;
        m_addr = '0;
        for (int i = 0; i < 3; i++) mh[i] = '0;
    endtask

    task automatic model_edge();
        logic [23:0] pix;
        int dx, dy, idx;
        bit hit;
        pix = bus.i_data;
        hit = m_en && bus.i_de && mx >= m_px && mx < m_px + BW && my >= m_py && my < m_py + BH;
        if (hit) begin
            dx = mx - m_px;
            dy = my - m_py;
            idx = dy * BPR + dx / 8;
            m_addr = 11'(idx);
            if (rom[idx][7 - (dx % 8)]) pix = COLOR;
        end
        mh[2] = mh[1];
        mh[1] = mh[0];
        mh[0] = {bus.i_hs, bus.i_vs, bus.i_de, pix};
        if (bus.i_vs && !m_pvs) begin
            m_en = osd_en;
            m_px = int'(pos_x);
            m_py = int'(pos_y);
            my = 0;
        end else if (m_pde && !bus.i_de) begin
            my = (my < 4095) ? my + 1 : 4095;
        end
        mx = bus.i_de ? ((mx < 4095) ? mx + 1 : 4095) : 0;
        m_pvs = bus.i_vs;
        m_pde = bus.i_de;
    endtask

    // One clock: compare outputs against the model, then present the next inputs.
    task automatic drive(input bit r, input bit hs, input bit vs, input bit de, input logic [23:0] d);
        @(negedge clk);
        check("video", 32'({bus.o_hs, bus.o_vs, bus.o_de, bus.o_data}), 32'(mh[2]));
        check("rom_addr", 32'(bus.rom_addr), 32'(m_addr));
        rst_n = r;
        bus.i_hs = hs;
        bus.i_vs = vs;
        bus.i_de = de;
        bus.i_data = d;
        if (!r) model_reset();
        else model_edge();
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 24'($urandom));
    endtask

    task automatic vsync(input bit en, input int px, input int py);
        osd_en = en;
        pos_x = 12'(px);
        pos_y = 12'(py);
        drive(1, 0, 1, 0, 24'($urandom));
        drive(1, 0, 1, 0, 24'($urandom));
        blank(2);
    endtask

    // Directed probes of rom_addr: (line, pixel) whose hit must produce the given address.
    int pr_line [$];
    int pr_px   [$];
    int pr_addr [$];

    // chg: 0 none, 1 drop osd_en mid-frame, 2 randomize all config mid-frame.
    task automatic frame(input int w, input int lines, input bit en, input int px, input int py,
                         input int chg, input int chg_line, input int rst_line, input int rst_px);
        vsync(en, px, py);
        for (int l = 0; l < lines; l++) begin
            if (l == chg_line && chg == 1) osd_en = 0;
            if (l == chg_line && chg == 2) begin
                osd_en = 1'($urandom);
                pos_x = 12'($urandom_range(0, 40));
                pos_y = 12'($urandom_range(0, 10));
            end
            drive(1, 1, 0, 0, 24'($urandom));
            drive(1, 1, 0, 0, 24'($urandom));
            blank(2);
            for (int x = 0; x <= w; x++) begin
                if (l == rst_line && x == rst_px) begin
                    drive(0, 0, 0, 1, 24'($urandom));
                    #1;
                    check("rst_out", 32'({bus.o_hs, bus.o_vs, bus.o_de, bus.o_data}), 32'd0);
                    check("rst_addr", 32'(bus.rom_addr), 32'd0);
                    drive(0, 0, 0, 1, 24'($urandom));
                end
                drive(1, 0, 0, x < w, 24'($urandom));
                for (int p = 0; p < pr_line.size(); p++)
                    if (l == pr_line[p] && x == pr_px[p] + 1)
                        check("probe_addr", 32'(bus.rom_addr), 32'(pr_addr[p]));
            end
            blank(2);
        end
        blank(3);
    endtask

    // Bitmap byte 0 = A5 at pos (0,0): first eight pixels alternate as the bit pattern says.
    task automatic frame_a5();
        logic [7:0]  pat;
        logic [23:0] exp;
        pat = 8'hA5;
        vsync(1, 0, 0);
        for (int k = 0; k < 11; k++) begin
            drive(1, 0, 0, k < 8, 24'h001000 + 24'(k));
            if (k >= 3) begin
                exp = pat[7 - (k - 3)] ? COLOR : 24'h001000 + 24'(k - 3);
                check("a5_pixel", 32'(bus.o_data), 32'(exp));
            end
        end
        blank(4);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
        rom[0] = 8'hA5;
        bus.i_hs = 0; bus.i_vs = 0; bus.i_de = 0; bus.i_data = '0;
        model_reset();

        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 24'($urandom));
        check("reset_video", 32'({bus.o_hs, bus.o_vs, bus.o_de, bus.o_data}), 32'd0);
        check("reset_addr", 32'(bus.rom_addr), 32'd0);
        // Enable is set but no frame start yet: overlay must stay off.
        osd_en = 1;
        for (int i = 0; i < 6; i++) drive(1, 0, 0, i > 1, 24'($urandom));
        blank(3);

        frame_a5();

        pr_line.push_back(5); pr_px.push_back(10); pr_addr.push_back(0);
        pr_line.push_back(6); pr_px.push_back(18); pr_addr.push_back(33);
        frame(40, 8, 1, 10, 5, 0, -1, -1, -1);
        pr_line.delete(); pr_px.delete(); pr_addr.delete();

        frame(1920, 2, 1, 4000, 0, 0, -1, -1, -1);

        frame(40, 10, 1, 3, 1, 1, 4, -1, -1);
        frame(40, 10, 0, 3, 1, 0, -1, -1, -1);

        frame(36, 8, 1, 2, 0, 0, -1, 3, 7);
        frame(36, 8, 1, 2, 0, 0, -1, -1, -1);

        for (int f = 0; f < 10; f++)
            frame($urandom_range(16, 48), $urandom_range(4, 12), 1'($urandom),
                  $urandom_range(0, 40), $urandom_range(0, 10), $urandom_range(0, 2),
                  $urandom_range(0, 6), -1, -1);

        for (int f = 0; f < 3; f++)
            frame($urandom_range(16, 48), $urandom_range(4, 8), 0,
                  $urandom_range(0, 40), $urandom_range(0, 10), 0, -1, -1, -1);

        blank(4);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
